// File: rtl/ram_stream_reader_if.sv
// RAM port-b read bus and output word stream of the RAM stream reader.
// The master modport is the reader; the slave side is the RAM plus the consumer.
interface ram_stream_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              b_en;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output b_en, b_addr, out_valid, out_data, out_last,
        input  b_rdata, out_ready
    );

    modport slave (
        input  b_en, b_addr, out_valid, out_data, out_last,
        output b_rdata, out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a contiguous RAM range through port b and streams the words out.
// A 2-entry FIFO hides the 1-cycle read latency so back-to-back words flow.
module ram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic              busy_o,
    output logic              done_o,
    ram_stream_reader_if.master bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_data_q [2];
    logic [DATA_W-1:0] mem_data_d [2];
    logic              mem_last_q [2];
    logic              mem_last_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic              head_last;
    logic [2:0]        occ;

    // A read may only issue if the word will find room once it lands,
    // counting the word already in flight and any word leaving this cycle.
    always_comb begin
        valid     = (cnt_q != 2'd0);
        pop       = valid && bus.out_ready;
        push      = inflight_q;
        head_last = mem_last_q[rd_ptr_q];
        occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == ST_RUN) && (issued_q < len_q) && (occ < 3'd2);

        bus.b_en      = issue;
        bus.b_addr    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
        bus.out_valid = valid;
        bus.out_data  = valid ? mem_data_q[rd_ptr_q] : '0;
        bus.out_last  = valid && head_last;
        busy_o        = (state_q == ST_RUN);
        done_o        = done_q;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        inflight_d  = issue;
        infl_last_d = issue && (issued_q == len_q - LEN_W'(1));
        mem_data_d  = mem_data_q;
        mem_last_d  = mem_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        base_d   = base_addr_i;
                        len_d    = length_i;
                        issued_d = '0;
                    end
                end
            end
            default: begin
                if (issue) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        // Push and pop touch different slots, so a full FIFO may do both.
        if (push) begin
            mem_data_d[wr_ptr_q] = bus.b_rdata;
            mem_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            mem_data_q  <= '{default: '0};
            mem_last_q  <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            mem_data_q  <= mem_data_d;
            mem_last_q  <= mem_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: expected addresses and words are
// queued at stimulus time and popped by a monitor on b_en / handshakes.
module tb_ram_stream_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] baseAddr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    ram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .start_i    (start),
        .base_addr_i(baseAddr),
        .length_i   (length),
        .busy_o     (busy),
        .done_o     (done),
        .bus        (bus)
    );

    logic [DATA_W-1:0] ram [1 << ADDR_W];
    logic [ADDR_W-1:0] addrQ [$];
    word_t             dataQ [$];
    word_t             monWord;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int issueCount  = 0;
    int validCount  = 0;
    int doneSeen    = 0;
    int doneExpected = 0;
    int startCycle  = 0;
    int lastDoneCycle = -1;
    int lastHsCycle   = -1;
    int firstBenCycle = -1;
    int firstValidCycle = -1;
    logic              prevStall = 1'b0;
    logic [DATA_W-1:0] prevData  = '0;
    logic              prevLast  = 1'b0;

    // RAM contents: i+8 in the low page, with an offset per page so that
    // upper address bits change the data.
    function automatic logic [DATA_W-1:0] ramVal(int a);
        int v;
        v = a + 8 + (a >> 8) * 37;
        return v[DATA_W-1:0];
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = ramVal(i);
    end

    // Registered read port: data appears the cycle after b_en.
    always @(posedge clock) begin
        if (bus.b_en) bus.b_rdata <= ram[bus.b_addr];
    end

    always @(posedge clock) cycleCount++;

    task automatic checkOutput(string name, int actual, int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s at cycle %0d", name, cycleCount);
    endtask

    // Monitor: pops the scoreboards on every b_en and every accepted word.
    always @(negedge clock) begin
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (bus.b_en) begin
                issueCount++;
                if (firstBenCycle < 0) firstBenCycle = cycleCount;
                if (addrQ.size() == 0) failNow("spurious b_en");
                else checkOutput("b_addr", int'(bus.b_addr), int'(addrQ.pop_front()));
            end else begin
                checkOutput("b_addr while idle", int'(bus.b_addr), 0);
            end
            if (bus.out_valid) begin
                validCount++;
                if (firstValidCycle < 0) firstValidCycle = cycleCount;
            end
            if (prevStall) begin
                checkOutput("out_valid held", int'(bus.out_valid), 1);
                checkOutput("out_data held", int'(bus.out_data), int'(prevData));
                checkOutput("out_last held", int'(bus.out_last), int'(prevLast));
            end
            if (bus.out_valid && bus.out_ready) begin
                lastHsCycle = cycleCount;
                if (dataQ.size() == 0) begin
                    failNow("spurious output word");
                end else begin
                    monWord = dataQ.pop_front();
                    checkOutput("out_data", int'(bus.out_data), int'(monWord.data));
                    checkOutput("out_last", int'(bus.out_last), int'(monWord.last));
                end
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevLast  = bus.out_last;
            if (done) begin
                doneSeen++;
                lastDoneCycle = cycleCount;
                checkOutput("busy low during done", int'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expectWord(int addr, int data, bit last);
        addrQ.push_back(ADDR_W'(addr));
        dataQ.push_back('{data: DATA_W'(data), last: last});
    endtask

    task automatic expectRange(int base, int len);
        for (int i = 0; i < len; i++)
            expectWord(base + i, int'(ramVal((base + i) % (1 << ADDR_W))), i == len - 1);
    endtask

    // Pulses start for one cycle; returns in the following cycle.
    task automatic applyStimulus(int base, int len);
        baseAddr = ADDR_W'(base);
        length   = LEN_W'(len);
        start    = 1'b1;
        startCycle = cycleCount;
        doneExpected++;
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(int budget, int mode);
        int n;
        n = 0;
        while (busy || dataQ.size() != 0 || addrQ.size() != 0) begin
            if (n >= budget) begin
                failNow("timeout waiting for transfer end");
                break;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : ((n % 3) != 2);
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic endTest(string name);
        checkOutput({name, " done count"}, doneSeen, doneExpected);
        checkOutput({name, " addresses left"}, addrQ.size(), 0);
        checkOutput({name, " words left"}, dataQ.size(), 0);
    endtask

    initial begin
        int iBase;
        int vBase;
        int dBase;
        reset = 1'b1;
        start = 1'b0;
        baseAddr = '0;
        length = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset b_en", int'(bus.b_en), 0);
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset out_data", int'(bus.out_data), 0);
        checkOutput("reset out_last", int'(bus.out_last), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic transfer with exact cycle timing.
        $display("[TB] test 1: base 0, length 4");
        firstBenCycle = -1;
        firstValidCycle = -1;
        expectWord(0, 8, 0);
        expectWord(1, 9, 0);
        expectWord(2, 10, 0);
        expectWord(3, 11, 1);
        applyStimulus(0, 4);
        waitIdle(50, 0);
        checkOutput("t1 first b_en cycle", firstBenCycle - startCycle, 1);
        checkOutput("t1 first out_valid cycle", firstValidCycle - startCycle, 3);
        checkOutput("t1 last word cycle", lastHsCycle - startCycle, 6);
        checkOutput("t1 done cycle", lastDoneCycle - startCycle, 7);
        endTest("t1");

        // Backpressure from cycle 2 to 9: only two reads may be outstanding.
        $display("[TB] test 2: length 6 with stalled consumer");
        iBase = issueCount;
        expectRange(40, 6);
        applyStimulus(40, 6);
        tick();
        bus.out_ready = 1'b0;
        repeat (8) tick();
        checkOutput("t2 reads during stall", issueCount - iBase, 2);
        checkOutput("t2 words pending during stall", dataQ.size(), 6);
        waitIdle(50, 0);
        endTest("t2");

        // Address wrap at the top of the RAM.
        $display("[TB] test 3: base 1022, length 4");
        expectWord(1022, 117, 0);
        expectWord(1023, 118, 0);
        expectWord(0, 8, 0);
        expectWord(1, 9, 1);
        applyStimulus(1022, 4);
        waitIdle(50, 1);
        endTest("t3");

        // Zero length: immediate done, no traffic.
        $display("[TB] test 4: length 0");
        iBase = issueCount;
        vBase = validCount;
        applyStimulus(7, 0);
        repeat (3) tick();
        checkOutput("t4 done cycle", lastDoneCycle - startCycle, 1);
        checkOutput("t4 reads issued", issueCount - iBase, 0);
        checkOutput("t4 valid cycles", validCount - vBase, 0);
        endTest("t4");

        // Reset in cycle 4 of a length-8 run, then a fresh short transfer.
        $display("[TB] test 5: reset mid-transfer");
        expectRange(200, 8);
        applyStimulus(200, 8);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addrQ.delete();
        dataQ.delete();
        doneExpected--;
        dBase = doneSeen;
        @(negedge clock);
        checkOutput("t5 busy after reset", int'(busy), 0);
        checkOutput("t5 done after reset", int'(done), 0);
        checkOutput("t5 b_en after reset", int'(bus.b_en), 0);
        checkOutput("t5 b_addr after reset", int'(bus.b_addr), 0);
        checkOutput("t5 out_valid after reset", int'(bus.out_valid), 0);
        checkOutput("t5 out_data after reset", int'(bus.out_data), 0);
        checkOutput("t5 out_last after reset", int'(bus.out_last), 0);
        tick();
        repeat (3) tick();
        checkOutput("t5 no done after reset", doneSeen - dBase, 0);
        expectWord(5, 13, 0);
        expectWord(6, 14, 1);
        applyStimulus(5, 2);
        waitIdle(50, 0);
        endTest("t5");

        // A second start while busy must be ignored.
        $display("[TB] test 6: start while busy");
        dBase = doneSeen;
        expectRange(10, 5);
        applyStimulus(10, 5);
        tick();
        baseAddr = 10'd100;
        length   = 11'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        waitIdle(50, 1);
        checkOutput("t6 single done", doneSeen - dBase, 1);
        endTest("t6");

        // Full-size transfer with a periodic stall pattern.
        $display("[TB] test 7: length 1024 from base 300");
        expectRange(300, 1024);
        applyStimulus(300, 1024);
        waitIdle(4000, 1);
        endTest("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
